ex_issue_scoreboard: RTL and testbench
======================================

Name: ex_issue_scoreboard

Overview:
- Issue controller in front of the execute (ALU) stage.
- Tracks destination registers of in-flight operations in a 32-entry pending scoreboard and bounds the number of in-flight operations.
- Stalls decode→execute issue on RAW/WAW hazards or when the in-flight limit is reached; writeback clears entries.
- Also keeps a saturating stall-cycle counter and a sticky protocol-error flag.

Parameters:
MAX_INFLIGHT, 4, maximum operations issued but not yet written back (1..15)
STALL_CNT_W, 32, width of stall-cycle counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
flush  input  1  pipeline flush; clears all tracking state
issue_valid  input  1  decode presents an instruction for execute
issue_rd  input  5  destination register index
issue_rs1  input  5  source 1 index
issue_rs2  input  5  source 2 index
issue_use_rs1  input  1  instruction reads rs1
issue_use_rs2  input  1  instruction reads rs2
issue_ready  output  1  combinational; instruction may issue this cycle
wb_valid  input  1  ALU/writeback retires one operation (driven from result_ready path)
wb_rd  input  5  destination index being retired
inflight_cnt  output  $clog2(MAX_INFLIGHT+1)  registered count of in-flight ops
stall_cycles  output  STALL_CNT_W  registered saturating count of stalled cycles
sb_error  output  1  registered sticky protocol error

Behaviour:
- Reset (reset_n low, asynchronous): pending[31:0]=0, inflight_cnt=0, stall_cycles=0, sb_error=0. issue_ready reflects reset state (1 if no flush dependency; see below).
- pending[0] is hardwired 0: never set, and reads are always clear.
- hazard = (issue_use_rs1 & rs1_busy) | (issue_use_rs2 & rs2_busy) | rd_busy | (inflight_cnt == MAX_INFLIGHT).
  - rs1_busy = pending[issue_rs1]; likewise rs2_busy and rd_busy (rd_busy is the WAW check).
- issue_ready = !hazard; purely combinational from registered state and issue_* inputs.
- fire = issue_valid & issue_ready. A stalled issue_valid must be held stable by decode until fire.
- On fire: pending[issue_rd] <= 1 if issue_rd != 0. inflight_cnt increments for every fired op, including rd=0, because every issued op produces exactly one wb_valid.
- On wb_valid:
  - pending[wb_rd] <= 0.
  - inflight_cnt decrements.
  - If inflight_cnt == 0: sb_error <= 1 and the count stays 0.
  - If wb_rd != 0 and pending[wb_rd] == 0: sb_error <= 1.
- Simultaneous fire and wb_valid: inflight_cnt unchanged. If issue_rd == wb_rd (possible only with forwarding), the set wins and pending stays 1.
- Full: at inflight_cnt == MAX_INFLIGHT, issue stalls even with no register hazard. A same-cycle wb_valid does not unblock the full condition (registered count only).
- Stall counting: stall_cycles increments when issue_valid & !issue_ready, saturating at all-ones (no wrap).
- flush: at the next edge clears pending and inflight_cnt. It overrides fire and wb_valid that cycle and does not touch stall_cycles or sb_error. While flush is high, issue_ready is forced 0.
- sb_error clears only on reset.
- Latency: a writeback makes its register available to issue on the cycle after wb_valid (baseline).

Optional Feature:
- Macro: EX_SCOREBOARD_BYPASS_EN.
- Defined: a wb_valid in the current cycle masks pending[wb_rd] (when wb_rd != 0) in the rs1/rs2/rd busy checks. A dependent instruction then issues in the same cycle as the retiring writeback, and the execute stage forwards the value.
- Undefined: no masking; one extra stall cycle per RAW dependence.
- Full-condition behaviour is identical in both builds.

Decomposition:
- Shared pipeline package holds:
  - reg_idx_t (5-bit register index typedef)
  - NUM_REGS = 32
  - REG_ZERO = 0
- One sub-module, pending_bitmap: 32-bit set/clear array with hardwired bit 0, set-wins priority and synchronous clear-all. It has two read ports for rs1/rs2 plus one for rd.
- Hazard logic, counters and error flag stay in the top module.

Test Plan:
- Reset, then issue rd=5 (no sources) → issue_ready=1, fire; next cycle pending[5]=1, inflight_cnt=1.
- RAW stall: issue rd=5, then rs1=5, use_rs1=1 → issue_ready=0 and stall_cycles increments each cycle. wb_valid rd=5 → issue_ready=1 the following cycle (same cycle with EX_SCOREBOARD_BYPASS_EN).
- Full: MAX_INFLIGHT=4, issue rd=1..4 without writeback → fifth issue (rd=6) sees issue_ready=0. One wb_valid rd=1 → issue_ready=1 next cycle, inflight_cnt=3.
- x0 handling: issue rd=0 then rs1=0 → no stall, pending[0] stays 0, inflight_cnt=1. wb_valid rd=0 → inflight_cnt=0, sb_error=0.
- Protocol error: wb_valid rd=7 with pending[7]=0 → sb_error=1 next cycle and remains 1 until reset_n low.
- Flush mid-operation: three ops in flight, flush plus same-cycle fire and wb → next cycle pending=0, inflight_cnt=0, stall_cycles unchanged. Asserting reset_n low mid-stall clears all outputs immediately.

Source files
------------

// File: rtl/ex_issue_scoreboard_pkg.sv
// Shared pipeline types and constants for the execute-stage issue scoreboard.
package ex_issue_scoreboard_pkg;
  localparam int NUM_REGS = 32;
  typedef logic [4:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/ex_issue_scoreboard_pending_bitmap.sv
// 32-entry pending-destination bitmap: set-wins over clear, x0 hardwired clear,
// synchronous clear-all, three busy read ports (rs1, rs2, rd) plus the raw vector.
module ex_issue_scoreboard_pending_bitmap
  import ex_issue_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr_all,
  input  logic                set_en,
  input  reg_idx_t            set_idx,
  input  logic                clr_en,
  input  reg_idx_t            clr_idx,
  input  reg_idx_t            rs1_idx,
  input  reg_idx_t            rs2_idx,
  input  reg_idx_t            rd_idx,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                rd_busy,
  output logic [NUM_REGS-1:0] pending_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_idx] = 1'b0;
    // Set is applied after clear so a same-index retire and issue leaves the bit set.
    if (set_en) pending_d[set_idx] = 1'b1;
    pending_d[REG_ZERO] = 1'b0;
    if (clr_all) pending_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  assign rs1_busy  = pending_q[rs1_idx];
  assign rs2_busy  = pending_q[rs2_idx];
  assign rd_busy   = pending_q[rd_idx];
  assign pending_o = pending_q;

endmodule

// File: rtl/ex_issue_scoreboard.sv
// Decode-to-execute issue controller: RAW/WAW hazard and in-flight limit stalls,
// stall-cycle counter, sticky protocol error. EX_SCOREBOARD_BYPASS_EN enables same-cycle wb bypass.
module ex_issue_scoreboard
  import ex_issue_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              flush,
  input  logic                              issue_valid,
  input  logic [4:0]                        issue_rd,
  input  logic [4:0]                        issue_rs1,
  input  logic [4:0]                        issue_rs2,
  input  logic                              issue_use_rs1,
  input  logic                              issue_use_rs2,
  output logic                              issue_ready,
  input  logic                              wb_valid,
  input  logic [4:0]                        wb_rd,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt,
  output logic [STALL_CNT_W-1:0]            stall_cycles,
  output logic                              sb_error
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT+1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0]       inflight_cnt_q, inflight_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic                   sb_error_q, sb_error_d;

  logic                rs1_busy_raw, rs2_busy_raw, rd_busy_raw;
  logic                rs1_byp, rs2_byp, rd_byp;
  logic                rs1_busy, rs2_busy, rd_busy;
  logic [NUM_REGS-1:0] pending;
  logic                full, hazard, fire, wb_eff;

  ex_issue_scoreboard_pending_bitmap u_pending (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_all   (flush),
    .set_en    (fire),
    .set_idx   (issue_rd),
    .clr_en    (wb_eff),
    .clr_idx   (wb_rd),
    .rs1_idx   (issue_rs1),
    .rs2_idx   (issue_rs2),
    .rd_idx    (issue_rd),
    .rs1_busy  (rs1_busy_raw),
    .rs2_busy  (rs2_busy_raw),
    .rd_busy   (rd_busy_raw),
    .pending_o (pending)
  );

`ifdef EX_SCOREBOARD_BYPASS_EN
  // A retiring writeback hides its register from the busy checks; execute forwards the value.
  assign rs1_byp = wb_valid && (wb_rd != REG_ZERO) && (wb_rd == issue_rs1);
  assign rs2_byp = wb_valid && (wb_rd != REG_ZERO) && (wb_rd == issue_rs2);
  assign rd_byp  = wb_valid && (wb_rd != REG_ZERO) && (wb_rd == issue_rd);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
  assign rd_byp  = 1'b0;
`endif

  assign rs1_busy = rs1_busy_raw & ~rs1_byp;
  assign rs2_busy = rs2_busy_raw & ~rs2_byp;
  assign rd_busy  = rd_busy_raw & ~rd_byp;

  // Full uses the registered count only, so a same-cycle writeback never unblocks it.
  assign full   = (inflight_cnt_q == MAX_CNT);
  assign hazard = (issue_use_rs1 & rs1_busy) | (issue_use_rs2 & rs2_busy) | rd_busy | full;

  // Handshake: an op transfers on fire = issue_valid & issue_ready; a stalled
  // issue_valid stays asserted with stable operands until it fires.
  assign issue_ready = ~hazard & ~flush;
  assign fire        = issue_valid & issue_ready;
  assign wb_eff      = wb_valid & ~flush;

  always_comb begin
    inflight_cnt_d = inflight_cnt_q;
    stall_cycles_d = stall_cycles_q;
    sb_error_d     = sb_error_q;

    // Cycles held off by flush are not counted as hazard stalls.
    if (issue_valid && !issue_ready && !flush && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);

    if (flush) begin
      inflight_cnt_d = '0;
    end else begin
      if (wb_valid) begin
        if (inflight_cnt_q == '0) sb_error_d = 1'b1;
        if ((wb_rd != REG_ZERO) && !pending[wb_rd]) sb_error_d = 1'b1;
      end
      unique case ({fire, wb_valid})
        2'b10:   inflight_cnt_d = inflight_cnt_q + CNT_W'(1);
        2'b01:   if (inflight_cnt_q != '0) inflight_cnt_d = inflight_cnt_q - CNT_W'(1);
        default: inflight_cnt_d = inflight_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_cnt_q <= '0;
      stall_cycles_q <= '0;
      sb_error_q     <= 1'b0;
    end else begin
      inflight_cnt_q <= inflight_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      sb_error_q     <= sb_error_d;
    end
  end

  assign inflight_cnt = inflight_cnt_q;
  assign stall_cycles = stall_cycles_q;
  assign sb_error     = sb_error_q;

endmodule

// File: tb/tb_ex_issue_scoreboard.sv
// Directed bench for ex_issue_scoreboard: issue, RAW stall, full, x0, error, flush, async reset.
module tb_ex_issue_scoreboard;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_use_rs1, issue_use_rs2;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [2:0]  inflight_cnt;
  logic [31:0] stall_cycles;
  logic        sb_error;

  int n_cmp = 0;
  int n_err = 0;
  int exp_stall = 0;

  ex_issue_scoreboard #(.MAX_INFLIGHT(4), .STALL_CNT_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .inflight_cnt  (inflight_cnt),
    .stall_cycles  (stall_cycles),
    .sb_error      (sb_error)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic u1, input logic [4:0] rs2, input logic u2);
    issue_valid   = v;
    issue_rd      = rd;
    issue_rs1     = rs1;
    issue_use_rs1 = u1;
    issue_rs2     = rs2;
    issue_use_rs2 = u2;
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] rd);
    wb_valid = v;
    wb_rd    = rd;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [2:0] cnt, input logic err);
    chk({tag, "_cnt"},   {29'd0, inflight_cnt}, {29'd0, cnt});
    chk({tag, "_stall"}, stall_cycles, exp_stall);
    chk({tag, "_err"},   {31'd0, sb_error}, {31'd0, err});
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    drive_issue(0, 0, 0, 0, 0, 0);
    drive_wb(0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset", 3'd0, 1'b0);
    chk("reset_ready", {31'd0, issue_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Basic issue rd=5
    drive_issue(1, 5, 0, 0, 0, 0);
    chk("issue5_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    drive_issue(0, 5, 0, 0, 0, 0);
    chk_regs("issue5", 3'd1, 1'b0);
    chk("waw5_ready", {31'd0, issue_ready}, 32'd0);

    // RAW on x5
    drive_issue(1, 8, 5, 1, 0, 0);
    chk("raw_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    exp_stall = 1;
    chk("raw_stall1", stall_cycles, exp_stall);
    tick();
    exp_stall = 2;
    chk("raw_stall2", stall_cycles, exp_stall);
    drive_wb(1, 5);
`ifdef EX_SCOREBOARD_BYPASS_EN
    chk("raw_wb_same", {31'd0, issue_ready}, 32'd1);
    tick();
    drive_wb(0, 0);
    drive_issue(0, 0, 0, 0, 0, 0);
    chk_regs("raw_byp", 3'd1, 1'b0);
`else
    chk("raw_wb_same", {31'd0, issue_ready}, 32'd0);
    tick();
    exp_stall = 3;
    drive_wb(0, 0);
    chk("raw_wb_next", {31'd0, issue_ready}, 32'd1);
    chk_regs("raw_after_wb", 3'd0, 1'b0);
    tick();
    drive_issue(0, 0, 0, 0, 0, 0);
    chk("raw_fired_cnt", {29'd0, inflight_cnt}, 32'd1);
`endif
    drive_wb(1, 8);
    tick();
    drive_wb(0, 0);
    chk_regs("retire8", 3'd0, 1'b0);

    // Full: four ops in flight
    for (int i = 1; i <= 4; i++) begin
      drive_issue(1, 5'(i), 0, 0, 0, 0);
      tick();
    end
    drive_issue(1, 6, 0, 0, 0, 0);
    chk("full_ready", {31'd0, issue_ready}, 32'd0);
    chk("full_cnt", {29'd0, inflight_cnt}, 32'd4);
    drive_wb(1, 1);
    chk("full_wb_same", {31'd0, issue_ready}, 32'd0);
    tick();
    exp_stall++;
    drive_wb(0, 0);
    chk("full_wb_next", {31'd0, issue_ready}, 32'd1);
    chk_regs("full_after_wb", 3'd3, 1'b0);
    tick();
    drive_issue(0, 0, 0, 0, 0, 0);
    chk("full_refill", {29'd0, inflight_cnt}, 32'd4);
    drive_wb(1, 2); tick();
    drive_wb(1, 3); tick();
    drive_wb(1, 4); tick();
    drive_wb(1, 6); tick();
    drive_wb(0, 0);
    chk_regs("full_drain", 3'd0, 1'b0);

    // x0 handling
    drive_issue(1, 0, 0, 0, 0, 0);
    chk("x0_rd_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    chk("x0_cnt1", {29'd0, inflight_cnt}, 32'd1);
    drive_issue(1, 0, 0, 1, 0, 1);
    chk("x0_rs_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    drive_issue(0, 0, 0, 0, 0, 0);
    chk("x0_cnt2", {29'd0, inflight_cnt}, 32'd2);
    drive_wb(1, 0); tick();
    drive_wb(1, 0); tick();
    drive_wb(0, 0);
    chk_regs("x0_drain", 3'd0, 1'b0);

    // Protocol error: retire x7 which was never issued
    drive_issue(1, 10, 0, 0, 0, 0);
    tick();
    drive_issue(0, 0, 0, 0, 0, 0);
    drive_wb(1, 7);
    tick();
    drive_wb(0, 0);
    chk_regs("proto_err", 3'd0, 1'b1);
    tick();
    chk("err_sticky", {31'd0, sb_error}, 32'd1);

    // Flush with same-cycle issue and writeback
    for (int i = 11; i <= 13; i++) begin
      drive_issue(1, 5'(i), 0, 0, 0, 0);
      tick();
    end
    chk("pre_flush_cnt", {29'd0, inflight_cnt}, 32'd3);
    flush = 1'b1;
    drive_issue(1, 14, 0, 0, 0, 0);
    drive_wb(1, 11);
    chk("flush_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    flush = 1'b0;
    drive_wb(0, 0);
    drive_issue(0, 12, 13, 1, 10, 1);
    chk_regs("post_flush", 3'd0, 1'b1);
    chk("flush_clr_ready", {31'd0, issue_ready}, 32'd1);
    drive_issue(0, 14, 0, 0, 0, 0);
    chk("flush_no_fire", {31'd0, issue_ready}, 32'd1);

    // Asynchronous reset during a stall
    drive_issue(1, 15, 0, 0, 0, 0);
    tick();
    drive_issue(1, 16, 15, 1, 0, 0);
    tick();
    exp_stall++;
    chk("pre_reset_stall", stall_cycles, exp_stall);
    #2;
    reset_n = 1'b0;
    #1;
    exp_stall = 0;
    chk_regs("async_reset", 3'd0, 1'b0);
    chk("async_reset_ready", {31'd0, issue_ready}, 32'd1);
    drive_issue(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Underflow: writeback with nothing in flight
    drive_wb(1, 0);
    tick();
    drive_wb(0, 0);
    chk_regs("underflow", 3'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
